joy_input_cond: RTL and testbench

Input conditioner for the 8-line active-low arcade joystick/button harness. Sits directly upstream of the game graphics/logic block. It synchronises the raw pad lines into `clk`, debounces each line, and produces clean active-high levels plus one-cycle press/release pulses. It also holds a single-entry jump request that stays pending until the game logic acknowledges it.

---
 rtl/joy_input_cond.sv | 196 +++++++++++++++++++
 tb/tb_joy_input_cond.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_input_cond.sv
// ---------------------------------------------------------------------------
// joy_input_cond
//
// Input conditioner for the 8-line active-low arcade joystick/button harness.
// Each raw pad line is brought into the clk domain with a two-flop
// synchroniser. It is inverted to active-high and then debounced by its own
// counter. The block outputs clean levels, one-cycle press and release pulses,
// and a single-entry jump request that waits for the game logic to acknowledge.
//
// Optional feature macro: JOY_AUTOREPEAT_EN
//   When defined, the direction bits (LFT, DN, UP, RGT) emit extra press
//   pulses while held. The first extra pulse comes REPEAT_DELAY cycles after
//   the press pulse, and the next ones come every REPEAT_PERIOD cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   REPEAT_DELAY     hold time before the first auto-repeat pulse
//   REPEAT_PERIOD    spacing of later auto-repeat pulses (<= REPEAT_DELAY)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   joy_n[7:0]   raw pad lines, active-low, asynchronous
//                [0] LFT [1] S3 [2] DN [3] S2 [4] UP [5] S1 [6] START [7] RGT
//   btn_level    debounced levels, 1 = pressed
//   btn_press    one-cycle press pulses (plus auto-repeat pulses)
//   btn_release  one-cycle release pulses
//   btn1         {RGT, LFT} levels
//   btn2         {DN, UP} levels
//   effect       S3 level
//   jump_req     pending jump request, set by an S2 press
//   jump_ack     acknowledge from the consumer, single-cycle or held
// ---------------------------------------------------------------------------
module joy_input_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 40000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] joy_n,
  output logic [7:0] btn_level,
  output logic [7:0] btn_press,
  output logic [7:0] btn_release,
  output logic [1:0] btn1,
  output logic [1:0] btn2,
  output logic       effect,
  output logic       jump_req,
  input  logic       jump_ack
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("joy_input_cond: DEBOUNCE_CYCLES must be at least 2");
  end
  if ((REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
    $error("joy_input_cond: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
  end

  logic [7:0]       sync1_r;
  logic [7:0]       sync2_r;
  logic [7:0]       s_s;
  logic [7:0]       stable_r;
  logic [CNT_W-1:0] cnt_r [8];
  logic [7:0]       level_r;
  logic [7:0]       press_r;
  logic [7:0]       release_r;
  logic [7:0]       rpt_fire_s;
  logic             jump_req_r;

  // Two-flop synchroniser. It resets to the idle-high level, so no press
  // is seen just after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 8'hFF;
      sync2_r <= 8'hFF;
    end else begin
      sync1_r <= joy_n;
      sync2_r <= sync1_r;
    end
  end

  assign s_s = ~sync2_r;

  // Per-bit debounce. Any sample equal to the accepted level restarts the
  // count. A full run of differing samples toggles the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (s_s[i] == stable_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == DB_TERM) begin
          stable_r[i] <= ~stable_r[i];
          cnt_r[i]    <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef JOY_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_ZERO   = {RPT_W{1'b0}};
  // Direction bits only: RGT, UP, DN, LFT
  localparam logic [7:0] DIR_MASK = 8'h95;

  logic [RPT_W-1:0] rpt_cnt_r [8];

  // Repeat pulse decode. The "stable" term blocks a pulse in the cycle a
  // release is about to show on the level output.
  always_comb begin
    rpt_fire_s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (DIR_MASK[i] && level_r[i] && stable_r[i] && (rpt_cnt_r[i] == RPT_FIRE)) begin
        rpt_fire_s[i] = 1'b1;
      end else begin
        rpt_fire_s[i] = 1'b0;
      end
    end
  end

  // Repeat counters count cycles since the press pulse. After each repeat
  // pulse they reload so the next pulse comes REPEAT_PERIOD cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        rpt_cnt_r[i] <= RPT_ZERO;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!(DIR_MASK[i] && level_r[i] && stable_r[i])) begin
          rpt_cnt_r[i] <= RPT_ZERO;
        end else if (rpt_fire_s[i]) begin
          rpt_cnt_r[i] <= RPT_RELOAD;
        end else begin
          rpt_cnt_r[i] <= rpt_cnt_r[i] + RPT_ONE;
        end
      end
    end
  end
`else
  assign rpt_fire_s = 8'h00;
`endif

  // Registered level and edge pulses. A pulse shows in the same cycle the
  // level first takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r   <= 8'h00;
      press_r   <= 8'h00;
      release_r <= 8'h00;
    end else begin
      level_r   <= stable_r;
      press_r   <= (stable_r & ~level_r) | rpt_fire_s;
      release_r <= ~stable_r & level_r;
    end
  end

  // Single-entry jump request. A press wins over a same-cycle acknowledge.
  // Extra presses while it is pending are absorbed. Auto-repeat never
  // touches S2, so only real S2 presses feed the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_req_r <= 1'b0;
    end else if (press_r[3]) begin
      jump_req_r <= 1'b1;
    end else if (jump_ack) begin
      jump_req_r <= 1'b0;
    end else begin
      jump_req_r <= jump_req_r;
    end
  end

  assign btn_level   = level_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;
  assign btn1        = {level_r[7], level_r[0]};
  assign btn2        = {level_r[2], level_r[4]};
  assign effect      = level_r[1];
  assign jump_req    = jump_req_r;

endmodule

// File: tb/tb_joy_input_cond.sv
// ---------------------------------------------------------------------------
// Self-checking bench for joy_input_cond, using DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10 and REPEAT_PERIOD=3.
//
// The reference model works from the observable rules:
//   - The accepted level takes value v once the active-high line, seen two
//     clocks late, has equalled v for DB consecutive samples.
//   - The output level lags the accepted level by one clock.
//   - Pulses are the edges of the output level.
//   - The jump request follows the press/ack priority.
// Directed literal checks pin the absolute latencies.
// ---------------------------------------------------------------------------
module tb_joy_input_cond;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] joy_n = 8'hFF;
  logic       jump_ack = 1'b0;
  logic [7:0] btn_level, btn_press, btn_release;
  logic [1:0] btn1, btn2;
  logic       effect, jump_req;

  joy_input_cond #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .joy_n      (joy_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn1       (btn1),
    .btn2       (btn2),
    .effect     (effect),
    .jump_req   (jump_req),
    .jump_ack   (jump_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

`ifdef JOY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] raw_h [$];
  logic [7:0] m_stable, m_level, m_press, m_release;
  logic       m_jreq;
  int         press_at [8];

  // Active-high line as seen at edge k. Before the pipeline fills it is idle.
  function automatic logic [7:0] s_at(input int k);
    if (k < 2) return 8'h00;
    return ~raw_h[k-2];
  endfunction

  initial begin
    logic [7:0] prev_level, prev_press, sv, so;
    int k;
    bit same;
    int dirs [4];
    dirs = '{0, 2, 4, 7};
    m_stable = 8'h00; m_level = 8'h00; m_press = 8'h00; m_release = 8'h00; m_jreq = 1'b0;
    for (int b = 0; b < 8; b++) press_at[b] = -1;
    forever begin
      @(posedge clk);
      if (rst) begin
        raw_h.delete();
        m_stable = 8'h00; m_level = 8'h00; m_press = 8'h00; m_release = 8'h00; m_jreq = 1'b0;
        for (int b = 0; b < 8; b++) press_at[b] = -1;
      end else begin
        prev_level = m_level;
        prev_press = m_press;
        raw_h.push_back(joy_n);
        k = raw_h.size() - 1;
        m_level = m_stable;
        if (k >= DB - 1) begin
          sv = s_at(k);
          for (int b = 0; b < 8; b++) begin
            same = 1'b1;
            for (int j = 1; j < DB; j++) begin
              so = s_at(k - j);
              if (so[b] != sv[b]) same = 1'b0;
            end
            if (same) m_stable[b] = sv[b];
          end
        end
        m_press   = m_level & ~prev_level;
        m_release = ~m_level & prev_level;
        if (AR) begin
          foreach (dirs[d]) begin
            if (m_level[dirs[d]] && !prev_level[dirs[d]]) press_at[dirs[d]] = k;
            else if (!m_level[dirs[d]]) press_at[dirs[d]] = -1;
            if (press_at[dirs[d]] >= 0 && (k - press_at[dirs[d]]) >= RD &&
                ((k - press_at[dirs[d]] - RD) % RP) == 0)
              m_press[dirs[d]] = 1'b1;
          end
        end
        if (prev_press[3]) m_jreq = 1'b1;
        else if (jump_ack) m_jreq = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("level",   {24'd0, btn_level},   {24'd0, m_level});
        chk("press",   {24'd0, btn_press},   {24'd0, m_press});
        chk("release", {24'd0, btn_release}, {24'd0, m_release});
        chk("btn1",    {30'd0, btn1},        {30'd0, m_level[7], m_level[0]});
        chk("btn2",    {30'd0, btn2},        {30'd0, m_level[2], m_level[4]});
        chk("effect",  {31'd0, effect},      {31'd0, m_level[1]});
        chk("jump_req",{31'd0, jump_req},    {31'd0, m_jreq});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    tick(3);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset release: everything idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_out", {btn_level, btn_press, btn_release, 7'd0, jump_req}, 32'd0);
    end

    // Clean press on LFT
    joy_n[0] = 1'b0;
    tick(6);
    chk("lft_not_yet", {31'd0, btn_level[0]}, 32'd0);
    tick(1);
    chk("lft_level", {31'd0, btn_level[0]}, 32'd1);
    chk("lft_press", {31'd0, btn_press[0]}, 32'd1);
    chk("lft_btn1",  {30'd0, btn1}, 32'd1);
    tick(1);
    chk("lft_press_1cyc", {31'd0, btn_press[0]}, 32'd0);
    tick(5);
    joy_n[0] = 1'b1;
    tick(6);
    chk("lft_rel_not_yet", {31'd0, btn_release[0]}, 32'd0);
    tick(1);
    chk("lft_release", {31'd0, btn_release[0]}, 32'd1);
    chk("lft_level0",  {31'd0, btn_level[0]}, 32'd0);
    tick(4);

    // Bounce on RGT: low 3, high 1, low 10
    joy_n[7] = 1'b0; tick(3);
    joy_n[7] = 1'b1; tick(1);
    joy_n[7] = 1'b0;
    tick(6);
    chk("rgt_glitch_quiet", {31'd0, btn_press[7]}, 32'd0);
    tick(1);
    chk("rgt_press", {31'd0, btn_press[7]}, 32'd1);
    tick(3);
    joy_n[7] = 1'b1;
    tick(10);

    // Jump handshake
    joy_n[3] = 1'b0;
    tick(7);
    chk("s2_press", {31'd0, btn_press[3]}, 32'd1);
    chk("jreq_before", {31'd0, jump_req}, 32'd0);
    tick(1);
    chk("jreq_set", {31'd0, jump_req}, 32'd1);
    tick(4);
    joy_n[3] = 1'b1; tick(12);
    joy_n[3] = 1'b0; tick(8);
    chk("jreq_absorbed", {31'd0, jump_req}, 32'd1);
    joy_n[3] = 1'b1; tick(10);
    jump_ack = 1'b1; tick(1);
    jump_ack = 1'b0;
    chk("jreq_ack", {31'd0, jump_req}, 32'd0);
    joy_n[3] = 1'b0;
    tick(7);
    chk("jreq_pre_coinc", {31'd0, jump_req}, 32'd0);
    jump_ack = 1'b1; tick(1);
    jump_ack = 1'b0;
    chk("jreq_press_wins", {31'd0, jump_req}, 32'd1);
    joy_n[3] = 1'b1;
    jump_ack = 1'b1; tick(2);
    jump_ack = 1'b0;
    tick(10);

    // Simultaneous changes on DN and START
    joy_n = 8'hBB;
    tick(7);
    chk("multi_press", {24'd0, btn_press}, 32'h44);
    joy_n = 8'hFF;
    tick(10);

    // Reset mid-debounce on S3
    joy_n[1] = 1'b0;
    tick(3);
    rst = 1'b1; tick(2);
    rst = 1'b0;
    tick(6);
    chk("s3_after_rst_early", {31'd0, effect}, 32'd0);
    tick(1);
    chk("s3_after_rst", {31'd0, effect}, 32'd1);
    joy_n[1] = 1'b1;
    tick(10);

    // Hold UP: auto-repeat pulses only in the repeat build
    joy_n[4] = 1'b0;
    tick(7);
    chk("up_press0", {31'd0, btn_press[4]}, 32'd1);
    for (int off = 1; off <= 17; off++) begin
      tick(1);
      chk($sformatf("up_rpt_off%0d", off), {31'd0, btn_press[4]},
          {31'd0, AR && (off == 10 || off == 13 || off == 16)});
    end
    joy_n[4] = 1'b1;
    tick(12);

    // Hold S1: never repeats
    joy_n[5] = 1'b0;
    tick(7);
    chk("s1_press0", {31'd0, btn_press[5]}, 32'd1);
    for (int off = 1; off <= 20; off++) begin
      tick(1);
      chk("s1_no_repeat", {31'd0, btn_press[5]}, 32'd0);
    end
    joy_n[5] = 1'b1;
    tick(10);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
